reaction_timer_ctrl: RTL
========================

// Module: reaction_timer_ctrl
// PURPOSE
//  Top-level sequencer for the reaction timer. Consumes debounced start/react button levels,
//  runs the IDLE→ARMED→GO→DONE game flow with a pseudo-random arm delay, and measures
//  reaction time in milliseconds for the display path. Detects false starts and timeouts.
// PARAMETERS
//  TICKS_PER_MS   50000  clk cycles per millisecond tick (>=2)
//  MIN_DELAY_MS   1000   fixed part of arm delay, ms
//  RAND_BITS      11     LFSR bits added to delay: delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]
//  MAX_MS         9999   reaction window; reaching it gives TIMEOUT
//  MS_W           14     width of ms counters/result (must hold MAX_MS and max delay)
// PORTS
//  clk           in   1     system clock
//  reset         in   1     synchronous, active-high
//  start_btn     in   1     debounced start button level
//  react_btn     in   1     debounced react button level
//  led_go        out  1     high only in GO
//  busy          out  1     high in ARMED or GO
//  result_ms     out  MS_W  last measured reaction time, held until next start
//  result_valid  out  1     high in DONE
//  early_flag    out  1     high in EARLY
//  timeout_flag  out  1     high in TIMEOUT
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, result_ms=0, lfsr=16'hACE1, prev-button regs=1
//    (so a button held through reset gives no press).
//  - Press = rising edge: btn & ~btn_prev, btn_prev registered each cycle. State changes
//    on the clk after the press cycle (1-cycle latency).
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle incl. IDLE; never all-zero.
//  - ms tick: prescaler counts 0..TICKS_PER_MS-1, tick on wrap; prescaler and ms counter
//    cleared on every state entry.
//  - IDLE/DONE/EARLY/TIMEOUT: start press → ARMED; delay_ms latched from the LFSR value in
//    the press cycle; result_ms cleared to 0; react press ignored.
//  - ARMED: react press → EARLY (has priority over delay expiry in the same cycle);
//    ms counter == delay_ms → GO. Start press ignored.
//  - GO: ms counter counts elapsed whole ms. React press → DONE, result_ms = ms counter
//    value in the press cycle (floor). ms counter reaching MAX_MS → TIMEOUT,
//    result_ms = MAX_MS. React press in the cycle MAX_MS is reached → DONE wins.
//    Start press ignored.
//  - Simultaneous start+react press: in IDLE/DONE/EARLY/TIMEOUT start wins; elsewhere
//    react rules apply.
//  - Flags are Moore outputs of the state; result_ms holds until the next start.
//  - Reset mid-operation: back to IDLE next cycle, no result/flag reported.
//  - ms counter saturates; no wrap-around possible in any state.
// TESTING (TICKS_PER_MS=4, MIN_DELAY_MS=3, RAND_BITS=2)
//  1. Reset, start press: ARMED next clk, busy=1; led_go rises after (3+lfsr[1:0])*4 clks.
//  2. React press exactly 10 clks after led_go rises: result_ms=2, result_valid=1,
//     led_go=0, busy=0.
//  3. React press while ARMED: EARLY, early_flag=1, led_go never rises; start press
//     re-arms, flag clears.
//  4. No react in GO, MAX_MS=5: TIMEOUT after 20 clks, result_ms=5, timeout_flag=1.
//  5. Start+react pressed same cycle in IDLE → ARMED; react held from reset → no press seen.
//  6. Assert reset during GO: next cycle IDLE, all outputs 0; button held at deassert gives
//     no transition.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer sequencer: IDLE -> ARMED -> GO -> DONE game flow with a
// pseudo-random arm delay, false-start (EARLY) and TIMEOUT detection.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999,
    parameter int MS_W         = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_btn,
    input  logic            react_btn,
    output logic            led_go,
    output logic            busy,
    output logic [MS_W-1:0] result_ms,
    output logic            result_valid,
    output logic            early_flag,
    output logic            timeout_flag,
    output logic [2:0]      dbg_state_o
);

    localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [PW-1:0]   PRESC_ONE = PW'(1);
    localparam logic [MS_W-1:0] MS_ONE    = MS_W'(1);
    localparam logic [MS_W-1:0] MS_MAX    = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0] MIN_DELAY = MS_W'(MIN_DELAY_MS);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_GO      = 3'd2,
        S_DONE    = 3'd3,
        S_EARLY   = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            start_prev_q, react_prev_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MS_W-1:0] ms_q, ms_d, ms_inc;
    logic [MS_W-1:0] delay_q, delay_d;
    logic [MS_W-1:0] result_q, result_d;
    logic            start_press, react_press, tick, lfsr_fb;

    assign start_press = start_btn & ~start_prev_q;
    assign react_press = react_btn & ~react_prev_q;
    assign tick        = (presc_q == TICK_LAST);
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running LFSR; the zero guard only matters if the register is ever upset.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
        if (lfsr_q == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end
    end

    // Millisecond value as it will be after this cycle, saturating.
    always_comb begin
        ms_inc = ms_q;
        if (tick && (ms_q != {MS_W{1'b1}})) begin
            ms_inc = ms_q + MS_ONE;
        end
    end

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: begin
                if (start_press) begin
                    state_d  = S_ARMED;
                    delay_d  = MIN_DELAY + MS_W'(lfsr_q[RAND_BITS-1:0]);
                    result_d = '0;
                end
            end
            S_ARMED: begin
                if (react_press) begin
                    state_d = S_EARLY;
                end else if (ms_inc == delay_q) begin
                    state_d = S_GO;
                end
            end
            S_GO: begin
                if (react_press) begin
                    state_d  = S_DONE;
                    result_d = ms_q;
                end else if (ms_inc >= MS_MAX) begin
                    state_d  = S_TIMEOUT;
                    result_d = MS_MAX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Timebase restarts from zero whenever a new state is entered.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PRESC_ONE;
        ms_d    = ms_inc;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            start_prev_q <= 1'b1;
            react_prev_q <= 1'b1;
            presc_q      <= '0;
            ms_q         <= '0;
            delay_q      <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start_btn;
            react_prev_q <= react_btn;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            delay_q      <= delay_d;
            result_q     <= result_d;
        end
    end

    assign led_go       = (state_q == S_GO);
    assign busy         = (state_q == S_ARMED) || (state_q == S_GO);
    assign result_valid = (state_q == S_DONE);
    assign early_flag   = (state_q == S_EARLY);
    assign timeout_flag = (state_q == S_TIMEOUT);
    assign result_ms    = result_q;
    assign dbg_state_o  = state_q;

endmodule
